conv_sequencer: RTL and testbench
=================================

CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameter PE_LAT, default 1, range 1..4: number of cycles from a tap being presented on s0/s1 to that tap's product being included in pe_out.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  request one 2x2 convolution job; sampled only in IDLE.
REQ-005 s0  output  4  matrix-a element select; index = row*4+col, zero-based (a11=0 ... a44=15).
REQ-006 s1  output  4  filter element select; index = row*3+col, zero-based (b11=0 ... b33=8).
REQ-007 pe_init  output  1  PE accumulator load strobe; the current product replaces the accumulator.
REQ-008 pe_preset  output  1  PE clear strobe.
REQ-009 pe_out  input  8  PE accumulated result.
REQ-010 busy  output  1  high while a job is in progress.
REQ-011 done  output  1  one-cycle pulse at job completion.
REQ-012 r11, r12, r21, r22  output  8 each  captured results for output positions (0,0), (0,1), (1,0) and (1,1).

Function
REQ-013 The FSM SHALL have the states IDLE, PRESET, RUN, DRAIN and DONE.
REQ-014 IDLE: busy=0; when start=1, next state is PRESET; otherwise stay in IDLE.
REQ-015 PRESET lasts exactly 1 cycle: pe_preset=1, s0=0, s1=0, pe_init=0, busy=1; next state is RUN with pos=0, tap=0.
REQ-016 RUN lasts exactly 36 cycles: positions pos=0..3 in order, taps tap=0..8 within each position, with no gap between positions.
REQ-017 In RUN, the block SHALL decode pr=pos[1], pc=pos[0], kr=tap/3, kc=tap%3.
REQ-018 In RUN, s0 SHALL equal (pr+kr)*4+(pc+kc).
REQ-019 In RUN, s1 SHALL equal kr*3+kc.
REQ-020 In RUN, pe_init=1 only when tap=0.
REQ-021 Outside RUN, s0=0, s1=0 and pe_init=0.
REQ-022 A capture strobe for position pos SHALL be generated in the cycle where tap=8 is presented.
REQ-023 The capture strobe SHALL be delayed by PE_LAT cycles through a shift register.
REQ-024 When the delayed strobe fires, pe_out SHALL be registered into r11, r12, r21 or r22 according to the delayed pos tag.
REQ-025 pe_out SHALL be captured as-is: 8-bit, with no saturation and no sign handling.
REQ-026 DRAIN lasts exactly PE_LAT cycles with busy=1; the last capture (r22) SHALL occur in its final cycle.
REQ-027 DONE lasts exactly 1 cycle: done=1, busy=0; next state is IDLE.
REQ-028 start SHALL be ignored in PRESET, RUN, DRAIN and DONE; it is not queued.
REQ-029 r11, r12, r21 and r22 SHALL hold their values until overwritten by a later capture or cleared by reset.
REQ-030 Timing, with start sampled at cycle 0:
  - PRESET at cycle 1.
  - RUN at cycles 2..37.
  - DONE at cycle 38+PE_LAT.

Reset
REQ-031 While rst=1, the following SHALL be 0 on the next edge:
  - state = IDLE.
  - s0, s1, pe_init, pe_preset.
  - busy, done.
  - r11, r12, r21, r22.
  - pos, tap and the capture shift register.
REQ-032 rst SHALL take priority over start and over any pending capture.
REQ-033 A reset mid-job SHALL produce no further captures and no done pulse.

Verification
REQ-034 Sequence trace: one start pulse, PE_LAT=1 -> s1 cycles through 0..8 four times; s0 follows the position table below; pe_init is high at cycles 2, 11, 20 and 29 only.

  position   s0 sequence
  pos0       0,1,2,4,5,6,8,9,10
  pos1       1,2,3,5,6,7,9,10,11
  pos2       4,5,6,8,9,10,12,13,14
  pos3       5,6,7,9,10,11,13,14,15

REQ-035 Results: behavioural PE model with all a=2 and all b=3 -> r11=r12=r21=r22=54; done high at cycle 39 only. With all a=16 and all b=2 -> all results 32 (288 mod 256).
REQ-036 Ignored start: start pulsed again at cycle 10 and at cycle 39 (the DONE cycle) -> exactly one done pulse; the block is in IDLE at cycle 40.
REQ-037 Reset mid-job: rst pulsed at cycle 20 -> at cycle 21 all outputs are 0, including r11 (no r11 capture survives); no done follows. A new start then completes normally with the correct results.
REQ-038 Latency variant: PE_LAT=3 with a model PE delayed 3 cycles -> done at cycle 41; results identical to PE_LAT=1.
REQ-039 Back-to-back jobs: start in the first IDLE cycle after done, with a changed to all 1 and b to all 1 -> the second job runs with no idle gap beyond that cycle; all results are 9.

Source files
------------

// File: rtl/conv_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : conv_sequencer_if
//  Description : Handshake and data bundle between the 2x2 convolution
//                sequencer (master) and its PE / job requester (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface conv_sequencer_if;
    logic       start;      // job request
    logic [3:0] s0;         // matrix-a element select
    logic [3:0] s1;         // filter element select
    logic       pe_init;    // PE accumulator load strobe
    logic       pe_preset;  // PE clear strobe
    logic [7:0] pe_out;     // PE accumulated result
    logic       busy;       // job in progress
    logic       done;       // job completion pulse
    logic [7:0] r11;        // result, output position (0,0)
    logic [7:0] r12;        // result, output position (0,1)
    logic [7:0] r21;        // result, output position (1,0)
    logic [7:0] r22;        // result, output position (1,1)

    modport master (
        input  start,
        input  pe_out,
        output s0,
        output s1,
        output pe_init,
        output pe_preset,
        output busy,
        output done,
        output r11,
        output r12,
        output r21,
        output r22
    );

    modport slave (
        output start,
        output pe_out,
        input  s0,
        input  s1,
        input  pe_init,
        input  pe_preset,
        input  busy,
        input  done,
        input  r11,
        input  r12,
        input  r21,
        input  r22
    );
endinterface
`default_nettype wire

// File: rtl/conv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_sequencer
//  Description : Sequences a 2x2 valid convolution of a 4x4 matrix with a
//                3x3 filter through an external multiply-accumulate PE.
//                Walks 4 output positions x 9 taps, then captures the PE
//                result for each position PE_LAT cycles after its last tap.
//  Revision    : 1.0  initial release
// ============================================================================
module conv_sequencer #(
    parameter int PE_LAT = 1    // tap-to-pe_out latency of the PE, 1..4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    conv_sequencer_if.master bus
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_PRESET = 3'd1;
    localparam logic [2:0] c_ST_RUN    = 3'd2;
    localparam logic [2:0] c_ST_DRAIN  = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    localparam logic [3:0] c_LAST_TAP   = 4'd8;
    localparam logic [1:0] c_LAST_POS   = 2'd3;
    localparam logic [2:0] c_DRAIN_LAST = 3'(PE_LAT - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0] r_state;
    logic [1:0] r_pos;          // output position, {row, col}
    logic [3:0] r_tap;          // filter tap within the position, 0..8
    logic [2:0] r_drain_cnt;    // cycles spent in DRAIN

    // Capture pipeline: a valid bit plus the position tag, PE_LAT stages deep
    logic       r_cap_vld [PE_LAT];
    logic [1:0] r_cap_tag [PE_LAT];

    logic [7:0] r_r11;
    logic [7:0] r_r12;
    logic [7:0] r_r21;
    logic [7:0] r_r22;

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic       w_in_run;
    logic       w_cap_stb;
    logic [1:0] w_kr;
    logic [1:0] w_kc;
    logic [1:0] w_row;
    logic [1:0] w_col;
    logic [3:0] w_s1;

    // Split the linear tap index into filter row/column (tap/3, tap%3)
    always_comb begin
        w_kr = 2'd0;
        w_kc = 2'd0;
        case (r_tap)
            4'd0:    begin w_kr = 2'd0; w_kc = 2'd0; end
            4'd1:    begin w_kr = 2'd0; w_kc = 2'd1; end
            4'd2:    begin w_kr = 2'd0; w_kc = 2'd2; end
            4'd3:    begin w_kr = 2'd1; w_kc = 2'd0; end
            4'd4:    begin w_kr = 2'd1; w_kc = 2'd1; end
            4'd5:    begin w_kr = 2'd1; w_kc = 2'd2; end
            4'd6:    begin w_kr = 2'd2; w_kc = 2'd0; end
            4'd7:    begin w_kr = 2'd2; w_kc = 2'd1; end
            4'd8:    begin w_kr = 2'd2; w_kc = 2'd2; end
            default: begin w_kr = 2'd0; w_kc = 2'd0; end
        endcase
    end

    assign w_in_run  = (r_state == c_ST_RUN);

    // Matrix coordinates never exceed 3, so row*4+col is just {row, col}
    assign w_row     = {1'b0, r_pos[1]} + w_kr;
    assign w_col     = {1'b0, r_pos[0]} + w_kc;
    assign w_s1      = ({2'b00, w_kr} * 4'd3) + {2'b00, w_kc};

    // The last tap of a position is on the bus; its result lands PE_LAT later
    assign w_cap_stb = w_in_run && (r_tap == c_LAST_TAP);

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.s0        = w_in_run ? {w_row, w_col} : 4'd0;
    assign bus.s1        = w_in_run ? w_s1 : 4'd0;
    assign bus.pe_init   = w_in_run && (r_tap == 4'd0);
    assign bus.pe_preset = (r_state == c_ST_PRESET);
    assign bus.busy      = (r_state == c_ST_PRESET) ||
                           (r_state == c_ST_RUN)    ||
                           (r_state == c_ST_DRAIN);
    assign bus.done      = (r_state == c_ST_DONE);
    assign bus.r11       = r_r11;
    assign bus.r12       = r_r12;
    assign bus.r21       = r_r21;
    assign bus.r22       = r_r22;

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Job FSM with position/tap walk and drain counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_pos       <= 2'd0;
            r_tap       <= 4'd0;
            r_drain_cnt <= 3'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= c_ST_PRESET;
                    end
                end
                c_ST_PRESET: begin
                    r_state <= c_ST_RUN;
                    r_pos   <= 2'd0;
                    r_tap   <= 4'd0;
                end
                c_ST_RUN: begin
                    if (r_tap == c_LAST_TAP) begin
                        r_tap <= 4'd0;
                        if (r_pos == c_LAST_POS) begin
                            r_state     <= c_ST_DRAIN;
                            r_pos       <= 2'd0;
                            r_drain_cnt <= 3'd0;
                        end else begin
                            r_pos <= r_pos + 2'd1;
                        end
                    end else begin
                        r_tap <= r_tap + 4'd1;
                    end
                end
                c_ST_DRAIN: begin
                    if (r_drain_cnt == c_DRAIN_LAST) begin
                        r_state     <= c_ST_DONE;
                        r_drain_cnt <= 3'd0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 3'd1;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Delay the capture strobe and its position tag to match the PE latency
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PE_LAT; i++) begin
                r_cap_vld[i] <= 1'b0;
                r_cap_tag[i] <= 2'd0;
            end
        end else begin
            r_cap_vld[0] <= w_cap_stb;
            r_cap_tag[0] <= r_pos;
            for (int i = 1; i < PE_LAT; i++) begin
                r_cap_vld[i] <= r_cap_vld[i-1];
                r_cap_tag[i] <= r_cap_tag[i-1];
            end
        end
    end

    // Store the PE result for the tagged position; values are kept raw
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r11 <= 8'd0;
            r_r12 <= 8'd0;
            r_r21 <= 8'd0;
            r_r22 <= 8'd0;
        end else if (r_cap_vld[PE_LAT-1]) begin
            case (r_cap_tag[PE_LAT-1])
                2'd0:    r_r11 <= bus.pe_out;
                2'd1:    r_r12 <= bus.pe_out;
                2'd2:    r_r21 <= bus.pe_out;
                default: r_r22 <= bus.pe_out;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_conv_sequencer
//  Description : Directed bench for conv_sequencer. Two instances (PE_LAT=1
//                and PE_LAT=3) each drive a behavioural MAC PE; expected
//                results are queued at job start and checked at done.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_conv_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    conv_sequencer_if ifa ();
    conv_sequencer_if ifb ();

    conv_sequencer #(.PE_LAT(1)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.master)
    );

    conv_sequencer #(.PE_LAT(3)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.master)
    );

    // ------------------------------------------------------------------------
    // Operand memories and behavioural PEs
    // ------------------------------------------------------------------------
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [9];

    function automatic logic [7:0] prod(input logic [3:0] ia, input logic [3:0] ib);
        logic [15:0] p;
        p = 16'(mem_a[ia]) * 16'(mem_b[ib]);
        return p[7:0];
    endfunction

    // Latency-1 PE: tap on the bus this cycle is in pe_out next cycle
    logic [7:0] r_acc_a = 8'd0;
    always_ff @(posedge clk) begin
        if (ifa.pe_preset)    r_acc_a <= 8'd0;
        else if (ifa.pe_init) r_acc_a <= prod(ifa.s0, ifa.s1);
        else                  r_acc_a <= r_acc_a + prod(ifa.s0, ifa.s1);
    end
    assign ifa.pe_out = r_acc_a;

    // Latency-3 PE: two input stages ahead of the accumulator
    logic       r_pre1 = 1'b0, r_pre2 = 1'b0, r_ini1 = 1'b0, r_ini2 = 1'b0;
    logic [7:0] r_prd1 = 8'd0, r_prd2 = 8'd0, r_acc_b = 8'd0;
    always_ff @(posedge clk) begin
        r_pre1 <= ifb.pe_preset;
        r_ini1 <= ifb.pe_init;
        r_prd1 <= prod(ifb.s0, ifb.s1);
        r_pre2 <= r_pre1;
        r_ini2 <= r_ini1;
        r_prd2 <= r_prd1;
        if (r_pre2)      r_acc_b <= 8'd0;
        else if (r_ini2) r_acc_b <= r_prd2;
        else             r_acc_b <= r_acc_b + r_prd2;
    end
    assign ifb.pe_out = r_acc_b;

    // ------------------------------------------------------------------------
    // Scoreboard, counters, helpers
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic [7:0] e11;
        logic [7:0] e12;
        logic [7:0] e21;
        logic [7:0] e22;
    } exp_t;

    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    // s0 for RUN cycle = base of position + offset of tap (position table)
    int s0_base [4] = '{0, 1, 4, 5};
    int s0_off  [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, done, pe_preset, pe_init, s0, s1}
    function automatic logic [11:0] status_of(input bit use_b);
        if (use_b) return {ifb.busy, ifb.done, ifb.pe_preset, ifb.pe_init, ifb.s0, ifb.s1};
        return {ifa.busy, ifa.done, ifa.pe_preset, ifa.pe_init, ifa.s0, ifa.s1};
    endfunction

    function automatic exp_t results_of(input bit use_b);
        if (use_b) return {ifb.r11, ifb.r12, ifb.r21, ifb.r22};
        return {ifa.r11, ifa.r12, ifa.r21, ifa.r22};
    endfunction

    // Expected status of the PE_LAT=1 instance, cycle 0 = start sampled
    function automatic logic [11:0] exp_status_lat1(input int c);
        int p;
        int t;
        logic [11:0] v;
        v = 12'd0;
        if (c == 1) begin
            v = {1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0};
        end else if (c >= 2 && c <= 37) begin
            p = (c - 2) / 9;
            t = (c - 2) % 9;
            v = {1'b1, 1'b0, 1'b0, (t == 0), 4'(s0_base[p] + s0_off[t]), 4'(t)};
        end else if (c == 38) begin
            v = {1'b1, 11'd0};
        end else if (c == 39) begin
            v = {1'b0, 1'b1, 10'd0};
        end
        return v;
    endfunction

    task automatic fill(input logic [7:0] va, input logic [7:0] vb, input bit idx_a);
        for (int i = 0; i < 16; i++) mem_a[i] = idx_a ? 8'(i) : va;
        for (int j = 0; j < 9; j++)  mem_b[j] = vb;
    endtask

    task automatic compare_results(input bit use_b);
        exp_t e;
        exp_t o;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            o = results_of(use_b);
            check("r11", 32'(o.e11), 32'(e.e11));
            check("r12", 32'(o.e12), 32'(e.e12));
            check("r21", 32'(o.e21), 32'(e.e21));
            check("r22", 32'(o.e22), 32'(e.e22));
        end
    endtask

    // Start a job in the current cycle, wait for done, check timing/results
    task automatic run_job(input bit use_b, input int lat, input exp_t e);
        int  cyc;
        bit  seen;
        sb_q.push_back(e);
        if (use_b) ifb.start = 1'b1; else ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        cyc  = 1;
        seen = 1'b0;
        check("job_preset", 32'(status_of(use_b)), 32'({1'b1, 1'b0, 1'b1, 9'd0}));
        while (!seen && cyc < 80) begin
            if (status_of(use_b)[10]) seen = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        check("job_done_seen", 32'(seen), 32'd1);
        check("job_done_cycle", 32'(cyc), 32'(38 + lat));
        check("job_busy_at_done", 32'(status_of(use_b)[11]), 32'd0);
        compare_results(use_b);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int n_done;
        rst       = 1'b1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        fill(8'd2, 8'd3, 1'b0);
        repeat (3) tick();

        // Reset state of both instances
        check("reset_status_a", 32'(status_of(1'b0)), 32'd0);
        check("reset_results_a", results_of(1'b0), 32'd0);
        check("reset_status_b", 32'(status_of(1'b1)), 32'd0);
        check("reset_results_b", results_of(1'b1), 32'd0);
        rst = 1'b0;
        repeat (2) tick();

        // Full trace, a=2 b=3, extra start at cycles 10 and 39 ignored
        sb_q.push_back('{8'd54, 8'd54, 8'd54, 8'd54});
        ifa.start = 1'b1;
        tick();
        n_done = 0;
        for (int c = 1; c <= 42; c++) begin
            check($sformatf("trace_c%0d", c), 32'(status_of(1'b0)), 32'(exp_status_lat1(c)));
            if (c == 12) check("r11_capture_c12", 32'(ifa.r11), 32'd54);
            if (ifa.done) begin
                n_done++;
                compare_results(1'b0);
            end
            ifa.start = (c == 10 || c == 39);
            tick();
        end
        ifa.start = 1'b0;
        check("single_done_pulse", 32'(n_done), 32'd1);

        // Wrapping sum: 9 * 16 * 2 = 288 -> 32
        fill(8'd16, 8'd2, 1'b0);
        run_job(1'b0, 1, '{8'd32, 8'd32, 8'd32, 8'd32});
        tick();

        // a[i]=i, b=1: sums of the s0 index sets of each position
        fill(8'd0, 8'd1, 1'b1);
        run_job(1'b0, 1, '{8'd45, 8'd54, 8'd81, 8'd90});
        tick();

        // Reset mid-job at cycle 20
        fill(8'd2, 8'd3, 1'b0);
        ifa.start = 1'b1;
        tick();
        ifa.start = 1'b0;
        repeat (19) tick();
        check("pre_reset_r11", 32'(ifa.r11), 32'd54);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_reset_status", 32'(status_of(1'b0)), 32'd0);
        check("mid_reset_results", results_of(1'b0), 32'd0);
        n_done = 0;
        for (int k = 0; k < 50; k++) begin
            if (ifa.done || ifa.busy) n_done++;
            tick();
        end
        check("no_activity_after_reset", 32'(n_done), 32'd0);
        check("no_capture_after_reset", results_of(1'b0), 32'd0);

        // Normal job after the aborted one, then back-to-back job
        run_job(1'b0, 1, '{8'd54, 8'd54, 8'd54, 8'd54});
        tick();
        check("idle_after_done", 32'(status_of(1'b0)), 32'd0);
        fill(8'd1, 8'd1, 1'b0);
        run_job(1'b0, 1, '{8'd9, 8'd9, 8'd9, 8'd9});
        tick();

        // PE_LAT=3 instance
        fill(8'd2, 8'd3, 1'b0);
        run_job(1'b1, 3, '{8'd54, 8'd54, 8'd54, 8'd54});
        tick();
        fill(8'd0, 8'd1, 1'b1);
        run_job(1'b1, 3, '{8'd45, 8'd54, 8'd81, 8'd90});
        tick();
        check("lat3_idle_after_done", 32'(status_of(1'b1)), 32'd0);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
